// File: rtl/memory_manager_pkg.sv
// memory_manager_pkg: display-phase codes and SRAM arbiter FSM states
// shared by memory_manager and its SRAM pin block.
package memory_manager_pkg;

    localparam logic [2:0] PHASE_IDLE   = 3'd0;
    localparam logic [2:0] PHASE_ACTIVE = 3'd1;
    localparam logic [2:0] PHASE_HBLANK = 3'd2;
    localparam logic [2:0] PHASE_VBLANK = 3'd3;

    typedef enum logic [3:0] {
        IDLE,
        V_ADDR,
        V_LATCH,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_ADDR,
        R_LATCH,
        WAIT_RELEASE
    } state_t;

    // Codes 4-7 are unused by the video timing and behave as HBLANK
    function automatic logic isHblankPhase(input logic [2:0] phase);
        return (phase == PHASE_HBLANK) || phase[2];
    endfunction

endpackage

// File: rtl/memory_manager_if.sv
// memory_manager_if: MCU side of the SRAM arbiter (level requests,
// one-cycle completion strobes).
interface memory_manager_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] memoryAddress;
    logic              memoryReadRequest;
    logic              memoryWriteRequest;
    logic [DATA_W-1:0] memoryWriteData;
    logic [DATA_W-1:0] memoryReadData;
    logic              memoryWriteComplete;
    logic              memoryReadComplete;

    modport master (
        output memoryAddress, memoryReadRequest, memoryWriteRequest,
        output memoryWriteData,
        input  memoryReadData, memoryWriteComplete, memoryReadComplete
    );

    modport slave (
        input  memoryAddress, memoryReadRequest, memoryWriteRequest,
        input  memoryWriteData,
        output memoryReadData, memoryWriteComplete, memoryReadComplete
    );
endinterface

// File: rtl/memory_manager_sram_port.sv
// sram_port: registered SRAM pins, ramData tristate driver and the
// input latches that capture the bus at the end of an OE-low cycle.
module sram_port
    import memory_manager_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadAddress,
    input  logic [DATA_W-1:0] loadData,
    input  logic              oeNext,
    input  logic              weNext,
    input  logic              driveNext,
    input  logic              captureVideo,
    input  logic              captureRead,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramOutputEnable,
    output logic              ramWriteEnable,
    output logic [DATA_W-1:0] videoLatch,
    output logic [DATA_W-1:0] readLatch,
    inout  wire  [DATA_W-1:0] ramData
);
    logic              drive;
    logic [DATA_W-1:0] writeData;

    assign ramData = drive ? writeData : {DATA_W{1'bz}};

    // Pin registers: strobes follow the FSM each cycle, address/data only on a new access
    always_ff @(posedge clock) begin
        if (reset) begin
            ramAddress      <= '0;
            writeData       <= '0;
            ramOutputEnable <= 1'b1;
            ramWriteEnable  <= 1'b1;
            drive           <= 1'b0;
        end else begin
            ramOutputEnable <= oeNext;
            ramWriteEnable  <= weNext;
            drive           <= driveNext;
            if (load) begin
                ramAddress <= loadAddress;
                writeData  <= loadData;
            end
        end
    end

    // Input latches: sample the bus as the OE-low cycle ends
    always_ff @(posedge clock) begin
        if (reset) begin
            videoLatch <= '0;
            readLatch  <= '0;
        end else begin
            if (captureVideo) videoLatch <= ramData;
            if (captureRead)  readLatch  <= ramData;
        end
    end
endmodule

// File: rtl/memory_manager.sv
// memory_manager: shares one SRAM between video fetch and the MCU.
// Define MEMORY_MANAGER_READBACK_EN to build the MCU read path.
module memory_manager
    import memory_manager_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int X_W    = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        currentState,
    input  logic [X_W-1:0]    videoAddress,
    output logic [DATA_W-1:0] videoData,
    output logic              videoDataReady,
    memory_manager_if.slave   mcu,
    output logic [ADDR_W-1:0] ramAddress,
    inout  wire  [DATA_W-1:0] ramData,
    output logic              ramOutputEnable,
    output logic              ramWriteEnable
);
    state_t            state, nextState;
    logic [7:0]        line;
    logic [2:0]        prevPhase;
    logic              activePhase, readRequest, captureRead;
    logic              load, oeNext, weNext, driveNext;
    logic [ADDR_W-1:0] fetchAddress, loadAddress;
    logic [DATA_W-1:0] readLatch;

    assign activePhase  = (currentState == PHASE_ACTIVE);
    assign fetchAddress = ADDR_W'({line, videoAddress});

`ifdef MEMORY_MANAGER_READBACK_EN
    assign readRequest        = mcu.memoryReadRequest;
    assign captureRead        = (state == R_ADDR);
    assign mcu.memoryReadData = readLatch;

    // Read-done strobe lands in R_LATCH together with the latched byte
    always_ff @(posedge clock) begin
        if (reset) mcu.memoryReadComplete <= 1'b0;
        else       mcu.memoryReadComplete <= (state == R_ADDR);
    end
`else
    logic [DATA_W:0] unusedRead;
    assign unusedRead             = {mcu.memoryReadRequest, readLatch};
    assign readRequest            = 1'b0;
    assign captureRead            = 1'b0;
    assign mcu.memoryReadData     = '0;
    assign mcu.memoryReadComplete = 1'b0;
`endif

    // Line counter: clear on VBLANK entry, count ACTIVE->HBLANK edges
    always_ff @(posedge clock) begin
        if (reset) begin
            line      <= '0;
            prevPhase <= PHASE_IDLE;
        end else begin
            prevPhase <= currentState;
            if (currentState == PHASE_VBLANK && prevPhase != PHASE_VBLANK)
                line <= '0;
            else if (prevPhase == PHASE_ACTIVE && isHblankPhase(currentState))
                line <= line + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Arbitration and pin commands for the state being entered
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (activePhase)                 nextState = V_ADDR;
                else if (mcu.memoryWriteRequest) nextState = W_SETUP;
                else if (readRequest)            nextState = R_ADDR;
            end
            V_ADDR:   nextState = V_LATCH;
            V_LATCH:  nextState = activePhase ? V_ADDR : IDLE;
            W_SETUP:  nextState = W_STROBE;
            W_STROBE: nextState = W_HOLD;
            W_HOLD:   nextState = WAIT_RELEASE;
            R_ADDR:   nextState = R_LATCH;
            R_LATCH:  nextState = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (!mcu.memoryWriteRequest && !readRequest)
                    nextState = IDLE;
            end
            default:  nextState = IDLE;
        endcase
        load        = nextState inside {V_ADDR, W_SETUP, R_ADDR};
        loadAddress = (nextState == V_ADDR) ? fetchAddress
                                            : mcu.memoryAddress;
        oeNext      = !(nextState inside {V_ADDR, R_ADDR});
        weNext      = (nextState != W_STROBE);
        driveNext   = nextState inside {W_SETUP, W_STROBE, W_HOLD};
    end

    // Strobes registered so each one coincides with the state it announces
    always_ff @(posedge clock) begin
        if (reset) begin
            videoDataReady          <= 1'b0;
            mcu.memoryWriteComplete <= 1'b0;
        end else begin
            videoDataReady          <= (state == V_ADDR);
            mcu.memoryWriteComplete <= (state == W_STROBE);
        end
    end

    sram_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sram_port (
        .clock          (clock),
        .reset          (reset),
        .load           (load),
        .loadAddress    (loadAddress),
        .loadData       (mcu.memoryWriteData),
        .oeNext         (oeNext),
        .weNext         (weNext),
        .driveNext      (driveNext),
        .captureVideo   (state == V_ADDR),
        .captureRead    (captureRead),
        .ramAddress     (ramAddress),
        .ramOutputEnable(ramOutputEnable),
        .ramWriteEnable (ramWriteEnable),
        .videoLatch     (videoData),
        .readLatch      (readLatch),
        .ramData        (ramData)
    );
endmodule

// File: tb/tb_memory_manager.sv
// tb_memory_manager: scoreboard bench with an SRAM model on ramData.
// Expectations adapt to MEMORY_MANAGER_READBACK_EN.
module tb_memory_manager;
    import memory_manager_pkg::*;

`ifdef MEMORY_MANAGER_READBACK_EN
    localparam int EXP_READS = 1;
`else
    localparam int EXP_READS = 0;
`endif

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  currentState;
    logic [8:0]  videoAddress;
    logic [7:0]  videoData;
    logic        videoDataReady;
    logic [16:0] ramAddress;
    tri1  [7:0]  ramData;
    logic        ramOutputEnable;
    logic        ramWriteEnable;

    memory_manager_if #(.ADDR_W(17), .DATA_W(8)) mcu ();

    memory_manager #(.ADDR_W(17), .DATA_W(8), .X_W(9)) dut (
        .clock          (clock),
        .reset          (reset),
        .currentState   (currentState),
        .videoAddress   (videoAddress),
        .videoData      (videoData),
        .videoDataReady (videoDataReady),
        .mcu            (mcu.slave),
        .ramAddress     (ramAddress),
        .ramData        (ramData),
        .ramOutputEnable(ramOutputEnable),
        .ramWriteEnable (ramWriteEnable)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wrDone = 0;
    int   rdDone = 0;
    logic monOn = 1'b0;
    exp_t vq[$];
    exp_t wq[$];
    exp_t rq[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ a[16:9] ^ {a[8], 7'h2D};
    endfunction

    // SRAM model: async read while OE low, write on each WE-low edge
    logic [7:0] mem [0:131071];
    initial for (int i = 0; i < 131072; i++) mem[i] = pat(17'(i));
    assign ramData = (!ramOutputEnable && ramWriteEnable)
                     ? mem[ramAddress] : 8'hzz;
    always @(posedge clock)
        if (!ramWriteEnable) mem[ramAddress] = ramData;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [16:0] a, input logic [7:0] d,
                                input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic activeBurst(input logic [8:0] x, input int len,
                               input logic [16:0] addr,
                               input logic [7:0] data,
                               input logic [2:0] after);
        int k;
        k = cyc;
        videoAddress = x;
        currentState = PHASE_ACTIVE;
        for (int j = 0; 2 * j + 1 <= len; j++)
            vq.push_back(mk(addr, data, k + 2 + 2 * j));
        step(len);
        currentState = after;
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clock) begin : mon
        exp_t e;
        if (monOn) begin
            if (!ramOutputEnable || !ramWriteEnable)
                check("oeWeExclusive",
                      32'(ramOutputEnable | ramWriteEnable), 1);
            if (!ramWriteEnable) begin
                check("writeExpected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("writeAddr", 32'(ramAddress), 32'(e.addr));
                    check("writeData", 32'(ramData), 32'(e.data));
                    if (e.cyc >= 0) check("writeCycle", cyc, e.cyc);
                end
            end
            if (videoDataReady) begin
                check("fetchExpected", 32'(vq.size() != 0), 1);
                if (vq.size() != 0) begin
                    e = vq.pop_front();
                    check("fetchData", 32'(videoData), 32'(e.data));
                    check("fetchAddr", 32'(ramAddress), 32'(e.addr));
                    check("fetchCycle", cyc, e.cyc);
                end
            end
            if (mcu.memoryWriteComplete) wrDone++;
            if (mcu.memoryReadComplete) begin
                rdDone++;
                check("readExpected", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    check("readData", 32'(mcu.memoryReadData),
                          32'(e.data));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        currentState = PHASE_IDLE;
        videoAddress = '0;
        mcu.memoryAddress = '0;
        mcu.memoryReadRequest = 1'b0;
        mcu.memoryWriteRequest = 1'b0;
        mcu.memoryWriteData = '0;
        step(3);
        check("rstWE", 32'(ramWriteEnable), 1);
        check("rstOE", 32'(ramOutputEnable), 1);
        check("rstBusZ", 32'(ramData), 32'hFF);
        check("rstAddr", 32'(ramAddress), 0);
        check("rstVideoData", 32'(videoData), 0);
        check("rstReadData", 32'(mcu.memoryReadData), 0);
        check("rstReady", 32'(videoDataReady), 0);
        check("rstWrDone", 32'(mcu.memoryWriteComplete), 0);
        check("rstRdDone", 32'(mcu.memoryReadComplete), 0);

        // reset while WE is low
        reset = 1'b0;
        monOn = 1'b1;
        currentState = PHASE_HBLANK;
        mcu.memoryAddress = 17'h1F000;
        mcu.memoryWriteData = 8'hEE;
        mcu.memoryWriteRequest = 1'b1;
        wq.push_back(mk(17'h1F000, 8'hEE, cyc + 2));
        for (int i = 0; i < 10 && ramWriteEnable; i++) step(1);
        check("weLowSeen", 32'(ramWriteEnable), 0);
        reset = 1'b1;
        mcu.memoryWriteRequest = 1'b0;
        step(1);
        check("abortWE", 32'(ramWriteEnable), 1);
        check("abortOE", 32'(ramOutputEnable), 1);
        check("abortBusZ", 32'(ramData), 32'hFF);
        check("abortNoStrobe", 32'(mcu.memoryWriteComplete), 0);
        reset = 1'b0;
        step(4);
        check("abortNoComplete", wrDone, 0);

        // build line = 2 from VBLANK
        currentState = PHASE_VBLANK;
        step(2);
        activeBurst(9'h010, 1, 17'h00010, pat(17'h00010), PHASE_HBLANK);
        step(3);
        activeBurst(9'h010, 1, 17'h00210, pat(17'h00210), PHASE_HBLANK);
        step(3);

        // HBLANK write, request held well past completion
        mcu.memoryAddress = 17'h005FF;
        mcu.memoryWriteData = 8'h03;
        mcu.memoryWriteRequest = 1'b1;
        wq.push_back(mk(17'h005FF, 8'h03, cyc + 2));
        for (int i = 0; i < 20 && wrDone < 1; i++) step(1);
        step(5);
        check("heldWriteOnce", wrDone, 1);
        mcu.memoryWriteRequest = 1'b0;
        step(2);

        // fetch of the written byte; write requested during ACTIVE waits
        mcu.memoryAddress = 17'h00123;
        mcu.memoryWriteData = 8'h5A;
        mcu.memoryWriteRequest = 1'b1;
        wq.push_back(mk(17'h00123, 8'h5A, cyc + 7));
        activeBurst(9'h1FF, 3, 17'h005FF, 8'h03, PHASE_HBLANK);
        for (int i = 0; i < 20 && wrDone < 2; i++) step(1);
        check("deferredWrite", wrDone, 2);
        mcu.memoryWriteRequest = 1'b0;
        step(2);

        // read and write together in VBLANK: write first
        currentState = PHASE_VBLANK;
        mcu.memoryAddress = 17'h00200;
        mcu.memoryWriteData = 8'hC3;
        mcu.memoryWriteRequest = 1'b1;
        mcu.memoryReadRequest = 1'b1;
        wq.push_back(mk(17'h00200, 8'hC3, cyc + 2));
        for (int i = 0; i < 20 && wrDone < 3; i++) step(1);
        step(4);
        check("writeWins", wrDone, 3);
        check("readHeldOff", rdDone, 0);
        mcu.memoryWriteRequest = 1'b0;
        mcu.memoryReadRequest = 1'b0;
        step(2);
        mcu.memoryReadRequest = 1'b1;
`ifdef MEMORY_MANAGER_READBACK_EN
        rq.push_back(mk(17'h00200, 8'hC3, -1));
        for (int i = 0; i < 20 && rdDone < 1; i++) step(1);
        step(3);
`else
        step(6);
        check("noReadData", 32'(mcu.memoryReadData), 0);
`endif
        check("readCount", rdDone, EXP_READS);
        mcu.memoryReadRequest = 1'b0;
        step(2);

        // three line ends (one via phase code 5), then VBLANK clear
        activeBurst(9'h010, 1, 17'h00010, pat(17'h00010), PHASE_HBLANK);
        step(3);
        activeBurst(9'h010, 1, 17'h00210, pat(17'h00210), 3'd5);
        step(3);
        activeBurst(9'h010, 1, 17'h00410, pat(17'h00410), PHASE_HBLANK);
        step(3);
        activeBurst(9'h010, 1, 17'h00610, pat(17'h00610), PHASE_HBLANK);
        step(3);
        currentState = PHASE_VBLANK;
        step(2);
        activeBurst(9'h010, 1, 17'h00010, pat(17'h00010), PHASE_HBLANK);
        step(6);

        check("fetchQueueEmpty", vq.size(), 0);
        check("writeQueueEmpty", wq.size(), 0);
        check("readQueueEmpty", rq.size(), 0);
        check("totalWrites", wrDone, 3);
        check("totalReads", rdDone, EXP_READS);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_manager.md
MEMORY_MANAGER -- requirements
Module: memory_manager

Interface
REQ-001 Parameters SHALL be: ADDR_W, 17, external SRAM address width; DATA_W, 8, SRAM data width; X_W, 9, video pixel-column width.
REQ-002 Ports SHALL be, in this order:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- currentState  in  3  display phase: 0 = IDLE, 1 = ACTIVE, 2 = HBLANK, 3 = VBLANK, 4-7 treated as HBLANK.
- videoAddress  in  X_W  pixel column for the video fetch.
- videoData  out  DATA_W  fetched pixel.
- videoDataReady  out  1  one-cycle strobe; videoData is valid.
- memoryAddress  in  ADDR_W  MCU address, {y[7:0], x[8:0]}.
- memoryReadRequest  in  1  MCU read request level.
- memoryWriteRequest  in  1  MCU write request level.
- memoryWriteData  in  DATA_W  MCU write data.
- memoryReadData  out  DATA_W  MCU read result.
- memoryWriteComplete  out  1  one-cycle write-done strobe.
- memoryReadComplete  out  1  one-cycle read-done strobe.
- ramAddress  out  ADDR_W  SRAM address.
- ramData  inout  DATA_W  SRAM data bus.
- ramOutputEnable  out  1  SRAM OE, active-low.
- ramWriteEnable  out  1  SRAM WE, active-low.

Function
REQ-003 All outputs SHALL be registered; ramData SHALL be driven only in write states and SHALL be high-Z otherwise.
REQ-004 Internal 8-bit line counter: cleared on entry to VBLANK; incremented on each ACTIVE->HBLANK transition; wraps at 255.
REQ-005 Video fetch address SHALL be {line[7:0], videoAddress}.
REQ-006 In ACTIVE, the block SHALL fetch every 2 cycles:
- cycle N: videoAddress sampled; ramAddress driven and OE low at N+1.
- cycle N+2: ramData latched into videoData; videoDataReady high for exactly that cycle.
REQ-007 Leaving ACTIVE mid-fetch SHALL let the fetch complete; no new fetch SHALL start outside ACTIVE.
REQ-008 MCU accesses SHALL be serviced only when currentState != ACTIVE and no video fetch is pending; requests made during ACTIVE SHALL wait.
REQ-009 FSM states: IDLE, V_ADDR, V_LATCH, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_LATCH, WAIT_RELEASE.
REQ-010 Write sequence:
- W_SETUP: address and data driven, WE high.
- W_STROBE: WE low for exactly 1 cycle.
- W_HOLD: WE high, data still driven, memoryWriteComplete pulsed.
- Then WAIT_RELEASE.
REQ-011 Read sequence:
- R_ADDR: address driven, OE low.
- R_LATCH: ramData latched into memoryReadData, memoryReadComplete pulsed.
- Then WAIT_RELEASE.
REQ-012 WAIT_RELEASE SHALL hold until both request inputs are low, then return to IDLE; a held request SHALL never cause a second access.
REQ-013 Simultaneous read and write requests: write SHALL win; the read is serviced after release.
REQ-014 OE and WE SHALL never be low in the same cycle; ramData SHALL be released one cycle before OE goes low.

Reset
REQ-015 Reset SHALL set: FSM to IDLE, line counter to 0, OE = WE = 1, ramData high-Z, ramAddress/videoData/memoryReadData = 0, all strobes = 0.
REQ-016 Reset asserted mid-write SHALL force WE high at the next edge; no completion strobe SHALL be issued.

Configuration
REQ-017 Macro MEMORY_MANAGER_READBACK_EN: when defined, the MCU read path (REQ-011) exists. When undefined, memoryReadRequest is ignored, memoryReadData = 0, and memoryReadComplete = 0.

Structure
REQ-018 Package memory_manager_pkg SHALL hold the display-phase constants (IDLE/ACTIVE/HBLANK/VBLANK) and the FSM state typedef.
REQ-019 One sub-module, sram_port, SHALL register ramAddress/OE/WE and own the ramData tristate and input latch.

Verification
REQ-020 Reset with WE forced low mid-write -> next edge WE=1, OE=1, ramData=Z, no complete strobe.
REQ-021 HBLANK, write addr 0x005FF, data 0x03 -> WE low exactly 1 cycle with ramAddress=0x005FF, ramData=0x03; one memoryWriteComplete pulse; request held 5 cycles produces no second write.
REQ-022 ACTIVE with line=2, videoAddress=0x1FF and SRAM model holding 0x03 at 0x005FF -> videoData=0x03 with videoDataReady 2 cycles later; a write request during ACTIVE waits until HBLANK.
REQ-023 Read and write requested in the same cycle during VBLANK -> write first, read after both requests drop; memoryReadData equals the SRAM content.
REQ-024 Three ACTIVE->HBLANK transitions after VBLANK -> fetch address upper byte = 3; VBLANK entry -> line counter = 0.
